// File: rtl/down_timer.sv
// Loadable down-counter with one-shot / periodic modes, terminal-count pulse and sticky expiry flag.
// state | meaning
// IDLE  | stopped; enab ignored until the next nonzero load
// RUN   | counting down on enabled cycles
module down_timer #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             enab,
    input  logic             mode,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt_out,
    output logic             tc,
    output logic             busy,
    output logic             expired
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             tc_q, tc_d;
    logic             expired_q, expired_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        reload_d  = reload_q;
        mode_d    = mode_q;
        tc_d      = 1'b0;
        expired_d = expired_q;

        if (load) begin
            cnt_d     = cnt_in;
            reload_d  = cnt_in;
            expired_d = 1'b0;
            if (cnt_in != CNT_ZERO) begin
                state_d = ST_RUN;
                mode_d  = mode;
            end else begin
                state_d = ST_IDLE;
            end
        end else if (enab && (state_q == ST_RUN)) begin
            if (cnt_q != CNT_ZERO) begin
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    tc_d = 1'b1;
                    // one-shot stops on the same edge that reaches zero
                    if (!mode_q) begin
                        state_d   = ST_IDLE;
                        expired_d = 1'b1;
                    end
                end
            end else begin
                // periodic mode spends one enabled cycle at zero before reloading
                cnt_d = reload_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            reload_q  <= '0;
            mode_q    <= 1'b0;
            tc_q      <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            reload_q  <= reload_d;
            mode_q    <= mode_d;
            tc_q      <= tc_d;
            expired_q <= expired_d;
        end
    end

    assign cnt_out = cnt_q;
    assign tc      = tc_q;
    assign expired = expired_q;
    assign busy    = (state_q == ST_RUN);

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus randomized traffic against a behavioural model.
module tb_down_timer;

    localparam int WIDTH = 5;

    logic             clk;
    logic             rst;
    logic             load;
    logic             enab;
    logic             mode;
    logic [WIDTH-1:0] cnt_in;
    logic [WIDTH-1:0] cnt_out;
    logic             tc;
    logic             busy;
    logic             expired;

    int n_checks = 0;
    int n_errors = 0;

    // behavioural model state
    int m_cnt      = 0;
    int m_reload   = 0;
    bit m_periodic = 0;
    bit m_running  = 0;
    bit m_expired  = 0;
    bit m_tc       = 0;

    down_timer #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .enab    (enab),
        .mode    (mode),
        .cnt_in  (cnt_in),
        .cnt_out (cnt_out),
        .tc      (tc),
        .busy    (busy),
        .expired (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit l, input bit e, input bit md, input int ci);
        m_tc = 0;
        if (r) begin
            m_cnt = 0; m_reload = 0; m_periodic = 0; m_running = 0; m_expired = 0;
        end else if (l) begin
            m_cnt     = ci;
            m_reload  = ci;
            m_expired = 0;
            m_running = (ci != 0);
            if (ci != 0) m_periodic = md;
        end else if (e && m_running) begin
            if (m_cnt > 0) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_tc = 1;
                    if (!m_periodic) begin
                        m_running = 0;
                        m_expired = 1;
                    end
                end
            end else begin
                m_cnt = m_reload;
            end
        end
    endtask

    task automatic cycle(input bit r, input bit l, input bit e, input bit md, input int ci);
        @(negedge clk);
        rst = r; load = l; enab = e; mode = md; cnt_in = ci[WIDTH-1:0];
        @(posedge clk);
        model_step(r, l, e, md, ci);
        #1;
        check("cnt_out", 32'(cnt_out), 32'(m_cnt));
        check("tc", 32'(tc), 32'(m_tc));
        check("busy", 32'(busy), 32'(m_running));
        check("expired", 32'(expired), 32'(m_expired));
    endtask

    initial begin
        int tc_pulses;
        int max_cnt;
        rst = 1'b0; load = 1'b0; enab = 1'b0; mode = 1'b0; cnt_in = '0;

        // reset with load asserted must still clear everything
        cycle(1, 1, 1, 1, 9);
        check("rst_cnt", 32'(cnt_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_expired", 32'(expired), 0);
        cycle(0, 0, 1, 0, 0);
        check("idle_enab_busy", 32'(busy), 0);

        // one-shot: 3,2,1,0
        cycle(0, 1, 0, 0, 3);
        check("os_load", 32'(cnt_out), 3);
        cycle(0, 0, 1, 0, 0); check("os_c2", 32'(cnt_out), 2);
        cycle(0, 0, 1, 0, 0); check("os_c1", 32'(cnt_out), 1); check("os_tc_early", 32'(tc), 0);
        cycle(0, 0, 1, 0, 0); check("os_c0", 32'(cnt_out), 0); check("os_tc", 32'(tc), 1);
        check("os_busy", 32'(busy), 0); check("os_expired", 32'(expired), 1);
        cycle(0, 0, 1, 0, 0); check("os_hold", 32'(cnt_out), 0); check("os_tc_once", 32'(tc), 0);
        check("os_sticky", 32'(expired), 1);

        // periodic: 2,1,0,2,1,0,2
        cycle(0, 1, 0, 1, 2);
        check("per_load", 32'(cnt_out), 2);
        check("per_expired_clr", 32'(expired), 0);
        tc_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 1, 0, 0);
            tc_pulses += int'(tc);
        end
        check("per_final", 32'(cnt_out), 2);
        check("per_tc_count", 32'(tc_pulses), 2);
        check("per_expired", 32'(expired), 0);

        // enable gaps: 4,3,3,2,2
        cycle(0, 1, 0, 0, 4);
        cycle(0, 0, 1, 0, 0); check("gap_3", 32'(cnt_out), 3);
        cycle(0, 0, 0, 0, 0); check("gap_3h", 32'(cnt_out), 3);
        cycle(0, 0, 1, 0, 0); check("gap_2", 32'(cnt_out), 2);
        cycle(0, 0, 0, 0, 0); check("gap_2h", 32'(cnt_out), 2); check("gap_tc", 32'(tc), 0);

        // reload override right before terminal count
        cycle(0, 1, 0, 0, 2);
        cycle(0, 0, 1, 0, 0); check("ovr_at1", 32'(cnt_out), 1);
        cycle(0, 1, 1, 0, 5);
        check("ovr_cnt", 32'(cnt_out), 5); check("ovr_tc", 32'(tc), 0);
        check("ovr_expired", 32'(expired), 0); check("ovr_busy", 32'(busy), 1);

        // load zero, then reset beats load
        cycle(0, 1, 1, 1, 0);
        check("lz_busy", 32'(busy), 0); check("lz_tc", 32'(tc), 0); check("lz_cnt", 32'(cnt_out), 0);
        cycle(0, 0, 1, 0, 0); check("lz_idle", 32'(busy), 0);
        cycle(0, 1, 0, 0, 6);
        cycle(0, 0, 1, 0, 0);
        cycle(1, 1, 1, 0, 7);
        check("rp_cnt", 32'(cnt_out), 0); check("rp_busy", 32'(busy), 0); check("rp_tc", 32'(tc), 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0, 0);
        check("rp_stay_idle", 32'(busy), 0);

        // boundary: full-scale periodic, 64 enabled cycles
        cycle(0, 1, 0, 1, 31);
        check("bnd_load", 32'(cnt_out), 31);
        tc_pulses = 0; max_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            cycle(0, 0, 1, 0, 0);
            tc_pulses += int'(tc);
            if (int'(cnt_out) > max_cnt) max_cnt = int'(cnt_out);
        end
        check("bnd_tc_pulses", 32'(tc_pulses), 2);
        check("bnd_max", 32'(max_cnt), 31);
        check("bnd_reload", 32'(cnt_out), 31);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit r, l, e, md;
            int ci;
            r  = ($urandom_range(0, 49) == 0);
            l  = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 3) != 0);
            md = $urandom_range(0, 1);
            ci = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 9));
            if ($urandom_range(0, 19) == 0) ci = 31;
            cycle(r, l, e, md, ci);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
